// File: rtl/mult_sequencer.sv
// mult_sequencer: radix-2 Booth sequential multiplier that drives an external
// add/sub ALU and retires one Booth iteration per clock.
//
// Optional feature macro: MULT_SEQUENCER_FLAGS_EN
//   defined   -> product_Z_out / product_N_out are registered on entry to DONE
//   undefined -> both flag ports are tied to 0
//
// Handshake: start_in is a request sampled only while the block is IDLE
// (busy_out low). Once accepted, busy_out stays high until the block returns
// to IDLE. done_out is a single-cycle pulse, and product_out is valid while
// done_out is high. product_out then holds until the next accepted start.
// state_dbg_out exposes the FSM state so that checkers can observe it.
module mult_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               start_in,
    input  logic [WIDTH-1:0]   mult_A_in,
    input  logic [WIDTH-1:0]   mult_B_in,
    output logic [WIDTH-1:0]   alu_A_out,
    output logic [WIDTH-1:0]   alu_B_out,
    output logic               alu_op_out,
    input  logic [WIDTH-1:0]   alu_result_in,
    output logic               busy_out,
    output logic               done_out,
    output logic [2*WIDTH-1:0] product_out,
    output logic               product_Z_out,
    output logic               product_N_out,
    output logic [1:0]         state_dbg_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] q;
    logic             q_1;
    logic [WIDTH-1:0] m;
    logic [CNT_W-1:0] cnt;

    logic             op_sub;
    logic             take_result;
    logic [WIDTH-1:0] a_sel;
    logic             addend_sign;
    logic             overflow;
    logic             true_sign;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] q_next;
    logic             last_iter;

    // Booth step: choose the ALU operation, then shift the selected value
    // right, inserting the true sign so that the ALU wrap-around is corrected.
    always_comb begin
        op_sub      = 1'b0;
        take_result = 1'b0;
        if (state == S_RUN) begin
            case ({q[0], q_1})
                2'b10:   begin op_sub = 1'b1; take_result = 1'b1; end
                2'b01:   take_result = 1'b1;
                default: take_result = 1'b0;
            endcase
        end
        a_sel       = take_result ? alu_result_in : a;
        // The sign of the effective addend is the sign of M, or of -M when subtracting.
        addend_sign = op_sub ? ~m[WIDTH-1] : m[WIDTH-1];
        overflow    = take_result && (a[WIDTH-1] == addend_sign)
                                  && (a_sel[WIDTH-1] != a[WIDTH-1]);
        true_sign   = a_sel[WIDTH-1] ^ overflow;
        a_next      = {true_sign, a_sel[WIDTH-1:1]};
        q_next      = {a_sel[0], q[WIDTH-1:1]};
        last_iter   = (state == S_RUN) && (cnt == CNT_W'(1));
    end

    // FSM and datapath registers: load on accepted start, iterate in RUN, hold otherwise.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= S_IDLE;
            a     <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            m     <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_in) begin
                        state <= S_RUN;
                        a     <= '0;
                        q     <= mult_B_in;
                        q_1   <= 1'b0;
                        m     <= mult_A_in;
                        cnt   <= CNT_W'(WIDTH);
                    end
                end
                S_RUN: begin
                    a   <= a_next;
                    q   <= q_next;
                    q_1 <= q[0];
                    cnt <= cnt - CNT_W'(1);
                    if (last_iter) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MULT_SEQUENCER_FLAGS_EN
    logic flag_z;
    logic flag_n;

    // Capture the flags from the final product as the FSM enters DONE.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (last_iter) begin
            flag_z <= ({a_next, q_next} == '0);
            flag_n <= a_next[WIDTH-1];
        end
    end

    assign product_Z_out = flag_z;
    assign product_N_out = flag_n;
`else
    assign product_Z_out = 1'b0;
    assign product_N_out = 1'b0;
`endif

    assign alu_A_out     = a;
    assign alu_B_out     = m;
    assign alu_op_out    = op_sub;
    assign busy_out      = (state != S_IDLE);
    assign done_out      = (state == S_DONE);
    assign product_out   = {a, q};
    assign state_dbg_out = state;

endmodule

// File: tb/tb_mult_sequencer.sv
// Testbench for mult_sequencer (WIDTH=16) with an ideal add/sub ALU attached.
// The reference product is plain signed multiplication of the operands.
module tb_mult_sequencer;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   op_a = '0;
    logic [W-1:0]   op_b = '0;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic           alu_op;
    logic [W-1:0]   alu_res;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic           prod_z;
    logic           prod_n;
    logic [1:0]     state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [2*W-1:0] exp_q[$];

    mult_sequencer #(.WIDTH(W)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .start_in      (start),
        .mult_A_in     (op_a),
        .mult_B_in     (op_b),
        .alu_A_out     (alu_a),
        .alu_B_out     (alu_b),
        .alu_op_out    (alu_op),
        .alu_result_in (alu_res),
        .busy_out      (busy),
        .done_out      (done),
        .product_out   (product),
        .product_Z_out (prod_z),
        .product_N_out (prod_n),
        .state_dbg_out (state_dbg)
    );

    // Ideal external ALU.
    assign alu_res = alu_op ? (alu_a - alu_b) : (alu_a + alu_b);

    // Clock generation.
    always #5 clk = ~clk;

    // Reference model: full-precision signed product.
    function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
    endfunction

    function automatic logic ref_z(input logic [2*W-1:0] p);
`ifdef MULT_SEQUENCER_FLAGS_EN
        return (p == '0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic ref_n(input logic [2*W-1:0] p);
`ifdef MULT_SEQUENCER_FLAGS_EN
        return p[2*W-1];
`else
        return 1'b0;
`endif
    endfunction

    // Run one multiplication. If pulse_cyc > 0, re-assert start with 2x2 in that cycle.
    task automatic run_mult(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int pulse_cyc);
        logic [2*W-1:0] exp;
        int done_cnt;
        int done_cyc;
        @(negedge clk);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        exp_q.push_back(ref_product(a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        done_cnt = 0;
        done_cyc = 0;
        exp = exp_q.pop_front();
        for (int cyc = 1; cyc <= W + 2; cyc++) begin
            @(negedge clk);
            if (cyc == pulse_cyc) begin
                start = 1'b1;
                op_a  = W'(2);
                op_b  = W'(2);
            end else if (pulse_cyc > 0 && cyc == pulse_cyc + 1) begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            n_checks++;
            if (busy !== (cyc <= W + 1)) begin
                n_errors++;
                $display("FAIL %s busy cyc=%0d: got %b want %b", name, cyc, busy, (cyc <= W + 1));
            end
            if (cyc > W) begin
                n_checks++;
                if (alu_op !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s alu_op_idle cyc=%0d: got %b want 0", name, cyc, alu_op);
                end
            end
            if (cyc >= W + 1) begin
                n_checks++;
                if (product !== exp) begin
                    n_errors++;
                    $display("FAIL %s product cyc=%0d: got %h want %h", name, cyc, product, exp);
                end
                n_checks++;
                if (prod_z !== ref_z(exp) || prod_n !== ref_n(exp)) begin
                    n_errors++;
                    $display("FAIL %s flags cyc=%0d: got Z=%b N=%b want Z=%b N=%b",
                             name, cyc, prod_z, prod_n, ref_z(exp), ref_n(exp));
                end
            end
        end
        start = 1'b0;
        n_checks++;
        if (done_cnt != 1 || done_cyc != W + 1) begin
            n_errors++;
            $display("FAIL %s done_pulse: got %0d pulses first at cyc %0d want 1 at cyc %0d",
                     name, done_cnt, done_cyc, W + 1);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({alu_a, alu_b, alu_op, busy, done, product, prod_z, prod_n} !== '0) begin
            n_errors++;
            $display("FAIL %s: got A=%h M=%h op=%b busy=%b done=%b P=%h Z=%b N=%b want all 0",
                     name, alu_a, alu_b, alu_op, busy, done, product, prod_z, prod_n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_reset_idle");
    endtask

    task automatic test_directed();
        run_mult("3x5", 16'd3, 16'd5, 0);
        run_mult("m3x5", 16'hFFFD, 16'd5, 0);
        run_mult("minxmin", 16'h8000, 16'h8000, 0);
        run_mult("0x1234", 16'h0000, 16'h1234, 0);
        run_mult("maxxmin", 16'h7FFF, 16'h8000, 0);
        run_mult("m1xm1", 16'hFFFF, 16'hFFFF, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_mult("random", W'($urandom), W'($urandom_range(0, 65535)), 0);
        end
    endtask

    task automatic test_ignore_start();
        run_mult("7x9_restart_ignored", 16'd7, 16'd9, 5);
    endtask

    task automatic test_reset_mid_run();
        int stray_done;
        @(negedge clk);
        start = 1'b1;
        op_a  = 16'd1234;
        op_b  = 16'hF00D;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid_run_immediate");
        @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_mid_run_held");
        rst = 1'b0;
        stray_done = 0;
        for (int cyc = 0; cyc < W + 4; cyc++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) stray_done++;
        end
        n_checks++;
        if (stray_done != 0) begin
            n_errors++;
            $display("FAIL reset_mid_run_no_done: got %0d busy/done cycles want 0", stray_done);
        end
        run_mult("4x4_after_reset", 16'd4, 16'd4, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_random();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    task automatic test_back_to_back();
        run_mult("b2b_0", 16'h8001, 16'h7FFF, 0);
        run_mult("b2b_1", 16'h0001, 16'h8000, 0);
        run_mult("b2b_2", 16'hAAAA, 16'h5555, 0);
    endtask

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits; legal values are WIDTH >= 2.
REQ-002 The block SHALL have port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start_in, input, 1 bit: start request, sampled only in IDLE.
REQ-005 The block SHALL have port mult_A_in, input, WIDTH bits: two's-complement multiplicand.
REQ-006 The block SHALL have port mult_B_in, input, WIDTH bits: two's-complement multiplier.
REQ-007 The block SHALL have port alu_A_out, output, WIDTH bits: the accumulator register A, driven to the external add/sub ALU.
REQ-008 The block SHALL have port alu_B_out, output, WIDTH bits: the latched multiplicand register M, driven to the ALU.
REQ-009 The block SHALL have port alu_op_out, output, 1 bit: 0 = add, 1 = subtract.
REQ-010 The block SHALL have port alu_result_in, input, WIDTH bits: the combinational ALU result for the current alu_A_out/alu_B_out/alu_op_out.
REQ-011 The block SHALL have port busy_out, output, 1 bit: high whenever state != IDLE.
REQ-012 The block SHALL have port done_out, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port product_out, output, 2*WIDTH bits: signed product {A,Q}.
REQ-014 The block SHALL have ports product_Z_out and product_N_out, outputs, 1 bit each: product zero flag and product negative flag.

Function
REQ-015 The block SHALL implement radix-2 Booth multiplication using registers A (WIDTH), Q (WIDTH), Q_1 (1 bit), M (WIDTH) and an iteration counter of clog2(WIDTH+1) bits.
REQ-016 The FSM SHALL have states IDLE, RUN and DONE: IDLE->RUN on start_in=1; RUN->DONE when the counter reaches 1; DONE->IDLE unconditionally after one cycle.
REQ-017 On accepting start in IDLE, the block SHALL load A=0, Q=mult_B_in, Q_1=0, M=mult_A_in and counter=WIDTH.
REQ-018 start_in SHALL be ignored in RUN and DONE; operand inputs SHALL be ignored except at the accepting edge.
REQ-019 In each RUN cycle, {Q[0],Q_1} SHALL select the operation: 10 -> alu_op_out=1 and take alu_result_in; 01 -> alu_op_out=0 and take alu_result_in; 00/11 -> alu_op_out=0 and keep A (result ignored).
REQ-020 In the same RUN cycle, the block SHALL register the arithmetic right shift of {A',Q,Q_1}, where A' is the selected value, and decrement the counter: exactly one iteration per cycle.
REQ-021 The bit shifted into A[WIDTH-1] SHALL be the true sign of A': msb(A') XOR signed overflow, with overflow computed locally from the signs of A, M (negated for subtract) and A'; this makes the most-negative x most-negative product correct.
REQ-022 Latency: if start is accepted at edge 0, RUN SHALL occupy cycles 1..WIDTH and done_out SHALL be high for exactly cycle WIDTH+1, in DONE.
REQ-023 product_out SHALL equal {A,Q} and SHALL hold its value from DONE until the next accepted start.
REQ-024 Outside RUN, alu_op_out SHALL be 0.

Reset
REQ-025 Asserting rst_in SHALL, asynchronously and at any time including mid-RUN, force IDLE and clear A, Q, Q_1, M, the counter, busy_out, done_out, product_out, product_Z_out and product_N_out to 0.
REQ-026 After rst_in deasserts, the block SHALL accept start on the first rising edge with start_in=1; no partial result is retained.

Configuration
REQ-027 With macro MULT_SEQUENCER_FLAGS_EN defined, product_Z_out SHALL be registered on entry to DONE as (product == 0) and product_N_out as product[2*WIDTH-1], both held with product_out; without the macro, both ports SHALL exist and be tied to 0.

Verification (WIDTH=16, ideal add/sub ALU model attached)
REQ-028 The bench SHALL cover: start with A=3, B=5 -> done_out pulses in cycle 17 after the start edge, product_out=0x0000000F.
REQ-029 The bench SHALL cover: A=-3 (0xFFFD), B=5 -> product_out=0xFFFFFFF1; with FLAGS_EN, N=1 and Z=0.
REQ-030 The bench SHALL cover: A=0x8000, B=0x8000 -> product_out=0x40000000.
REQ-031 The bench SHALL cover: A=0, B=0x1234 -> product_out=0; with FLAGS_EN, Z=1, otherwise Z=0.
REQ-032 The bench SHALL cover: start with 7x9, then start_in pulsed with 2x2 in cycle 5 -> second request ignored, product_out=63, single done_out pulse.
REQ-033 The bench SHALL cover: rst_in asserted in cycle 8 of a RUN -> all outputs 0 immediately, no done_out; a following 4x4 run yields 16.
